// File: rtl/lcd_ctrl.sv
// lcd_ctrl: serialises CPU command bytes and RGB565 pixel frames onto a
// byte-wide LCD PHY through a single registered output stage. A frame is a
// RAMWR command byte followed by high/low bytes of each pixel, optionally
// gated by a frame-mark pulse from the panel with a timeout fallback.
module lcd_ctrl #(
    parameter logic [7:0] RAMWR_CMD = 8'h2C,
    parameter int         FM_TO_W   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_rs,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_last,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        frame_go,
    input  logic        cfg_fm_sync,
    output logic [7:0]  phy_data,
    output logic        phy_rs,
    output logic        phy_valid,
    input  logic        phy_ready,
    input  logic        phy_fmark_stb,
    output logic        busy,
    output logic        frame_done_stb,
    output logic        fm_timeout_stb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FM,
        S_HDR,
        S_PIX_HI,
        S_PIX_LO,
        S_DONE
    } state_t;

    localparam logic [FM_TO_W-1:0] FM_CNT_MAX = {FM_TO_W{1'b1}};
    localparam logic [FM_TO_W-1:0] FM_CNT_ONE = FM_TO_W'(1);

    state_t             state_q;
    logic               frame_pend_q;
    logic               fm_sync_q;
    logic [FM_TO_W-1:0] fm_cnt_q;
    logic [7:0]         lo_byte_q;
    logic               last_q;
    logic [7:0]         phy_data_q;
    logic               phy_rs_q;
    logic               phy_valid_q;
    logic               frame_done_q;
    logic               fm_timeout_q;

    // The output register can take a new byte when empty or draining this cycle.
    logic               free;
    logic               load_en;
    logic [7:0]         load_data;
    logic               load_rs;

    assign free = ~phy_valid_q | phy_ready;

    // Select which byte (if any) enters the output register this cycle.
    always_comb begin
        load_en   = 1'b0;
        load_data = cmd_data;
        load_rs   = cmd_rs;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && free) begin
                    load_en   = 1'b1;
                    load_data = cmd_data;
                    load_rs   = cmd_rs;
                end
            end
            S_HDR: begin
                if (free) begin
                    load_en   = 1'b1;
                    load_data = RAMWR_CMD;
                    load_rs   = 1'b0;
                end
            end
            S_PIX_HI: begin
                if (pix_valid && free) begin
                    load_en   = 1'b1;
                    load_data = pix_data[15:8];
                    load_rs   = 1'b1;
                end
            end
            S_PIX_LO: begin
                if (free) begin
                    load_en   = 1'b1;
                    load_data = lo_byte_q;
                    load_rs   = 1'b1;
                end
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    // Handshakes are combinational so a byte can be accepted in the cycle it is offered.
    assign cmd_ready = rst_n & (state_q == S_IDLE) & cmd_valid & free;
    assign pix_ready = rst_n & (state_q == S_PIX_HI) & pix_valid & free;

    assign busy           = (state_q != S_IDLE) | frame_pend_q;
    assign phy_data       = phy_data_q;
    assign phy_rs         = phy_rs_q;
    assign phy_valid      = phy_valid_q;
    assign frame_done_stb = frame_done_q;
    assign fm_timeout_stb = fm_timeout_q;

    // PHY output register: holds its byte until the PHY accepts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phy_valid_q <= 1'b0;
            phy_data_q  <= 8'h00;
            phy_rs_q    <= 1'b0;
        end else if (load_en) begin
            phy_valid_q <= 1'b1;
            phy_data_q  <= load_data;
            phy_rs_q    <= load_rs;
        end else if (phy_ready) begin
            phy_valid_q <= 1'b0;
        end
    end

    // Low byte and end-of-frame flag of the pixel whose high byte goes out now.
    always_ff @(posedge clk) begin
        if (state_q == S_PIX_HI && pix_valid && free) begin
            lo_byte_q <= pix_data[7:0];
            last_q    <= pix_last;
        end
    end

    // Frame sequencer with pending-request latch, frame-mark wait and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            frame_pend_q <= 1'b0;
            fm_sync_q    <= 1'b0;
            fm_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            fm_timeout_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            fm_timeout_q <= 1'b0;
            // A request is only latched from an idle, un-pended controller.
            if (frame_go && !frame_pend_q && state_q == S_IDLE) begin
                frame_pend_q <= 1'b1;
                fm_sync_q    <= cfg_fm_sync;
            end
            case (state_q)
                S_IDLE: begin
                    // Commands win over a pending frame.
                    if (frame_pend_q && !cmd_valid) begin
                        frame_pend_q <= 1'b0;
                        fm_cnt_q     <= '0;
                        state_q      <= fm_sync_q ? S_WAIT_FM : S_HDR;
                    end
                end
                S_WAIT_FM: begin
                    // A real frame mark on the expiry cycle suppresses the timeout pulse.
                    if (phy_fmark_stb) begin
                        state_q <= S_HDR;
                    end else if (fm_cnt_q == FM_CNT_MAX) begin
                        state_q      <= S_HDR;
                        fm_timeout_q <= 1'b1;
                    end else begin
                        fm_cnt_q <= fm_cnt_q + FM_CNT_ONE;
                    end
                end
                S_HDR: begin
                    if (free) begin
                        state_q <= S_PIX_HI;
                    end
                end
                S_PIX_HI: begin
                    if (pix_valid && free) begin
                        state_q <= S_PIX_LO;
                    end
                end
                S_PIX_LO: begin
                    if (free) begin
                        state_q <= last_q ? S_DONE : S_PIX_HI;
                    end
                end
                S_DONE: begin
                    // Report completion only once the final byte has left the register.
                    if (!phy_valid_q) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter RAMWR_CMD, default 8'h2C: command byte sent (rs=0) at the start of every frame.
REQ-002 Parameter FM_TO_W, default 20: width of the frame-mark timeout counter; timeout = 2^FM_TO_W-1 cycles.
REQ-003 clk  in  1  sole clock, all logic rising-edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 cmd_data  in  8  command/parameter byte from CPU side.
REQ-006 cmd_rs  in  1  0=command, 1=data, passed to PHY unchanged.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  byte handshake; transfer when both high.
REQ-008 pix_data  in  16  RGB565 pixel.
REQ-009 pix_last  in  1  marks final pixel of frame, qualified by pix_valid.
REQ-010 pix_valid / pix_ready  in / out  1 / 1  pixel handshake; transfer when both high.
REQ-011 frame_go  in  1  single-cycle frame-start request.
REQ-012 cfg_fm_sync  in  1  1=wait for frame mark before frame, sampled at frame_go.
REQ-013 phy_data / phy_rs / phy_valid  out  8/1/1  to LCD PHY, registered.
REQ-014 phy_ready  in  1  PHY accepts byte when phy_valid & phy_ready.
REQ-015 phy_fmark_stb  in  1  single-cycle frame-mark pulse from PHY.
REQ-016 busy  out  1  high whenever state != IDLE or frame pending.
REQ-017 frame_done_stb / fm_timeout_stb  out  1 / 1  single-cycle status pulses.

Function
REQ-018 Output register: "free" = ~phy_valid | phy_ready; new byte loaded only when free; phy_data/phy_rs held stable while phy_valid & ~phy_ready.
REQ-019 phy_valid clears on the edge after a transfer when no new byte is loaded that cycle.
REQ-020 frame_go sets frame_pend (and latches cfg_fm_sync); frame_go while frame_pend or not IDLE is ignored.
REQ-021 States: IDLE, WAIT_FM, HDR, PIX_HI, PIX_LO, DONE.
REQ-022 IDLE: if cmd_valid & free -> load cmd_data/cmd_rs, cmd_ready=1 same cycle, stay IDLE (commands take priority over pending frame).
REQ-023 IDLE: if frame_pend & ~cmd_valid -> clear frame_pend, go WAIT_FM if latched sync else HDR.
REQ-024 cmd_ready is 0 in every state except IDLE.
REQ-025 WAIT_FM: counter counts from 0 each entry; phy_fmark_stb -> HDR; counter reaching 2^FM_TO_W-1 -> HDR with fm_timeout_stb=1 for one cycle; fmark and expiry same cycle -> no timeout pulse.
REQ-026 HDR: when free, load RAMWR_CMD with rs=0 -> PIX_HI.
REQ-027 PIX_HI: when pix_valid & free, load pix_data[15:8] rs=1, capture pix_data[7:0] and pix_last, pix_ready=1 that cycle -> PIX_LO.
REQ-028 PIX_LO: when free, load captured low byte rs=1; go DONE if captured last else PIX_HI.
REQ-029 pix_ready is combinational, high only under REQ-027 conditions; at most one pixel per two PHY bytes.
REQ-030 DONE: when phy_valid=0 (last byte transferred), frame_done_stb=1 one cycle -> IDLE.
REQ-031 Throughput: with phy_ready tied high, one byte per cycle sustained in pixel states, no bubble between PIX_HI/PIX_LO.
REQ-032 pix_valid without active frame never asserts pix_ready; pixels are not dropped.

Reset
REQ-033 rst_n low at an edge: state=IDLE, frame_pend=0, phy_valid=0, phy_data=8'h00, phy_rs=0, counter=0, all strobes 0.
REQ-034 Reset mid-frame or mid-transfer abandons the byte in flight; no frame_done_stb; cmd_ready/pix_ready 0 while rst_n low.

Verification
REQ-035 phy_ready=1, cmd bytes (0x36,rs0),(0x48,rs1) -> phy emits same two bytes on consecutive cycles, cmd_ready high for each.
REQ-036 frame_go, cfg_fm_sync=0, 2 pixels 0x1234, 0xABCD(last) -> phy bytes 2C(rs0),12,34,AB,CD(rs1), then one frame_done_stb.
REQ-037 phy_ready toggling 1/0 (half-speed PHY) during frame -> every byte held stable until accepted, order unchanged, no loss/duplicate.
REQ-038 cfg_fm_sync=1, phy_fmark_stb after 100 cycles -> 0x2C appears after fmark; with FM_TO_W=4 and no fmark -> fm_timeout_stb at cycle 15 of WAIT_FM, frame proceeds.
REQ-039 cmd_valid and frame_go same cycle in IDLE -> command byte sent first, then 0x2C.
REQ-040 rst_n low during PIX_LO -> next cycle phy_valid=0, state IDLE, busy=0; new frame_go after release runs normally.
